// File: rtl/bp_pkg.sv
// Shared types and helpers for the bimodal BTB predictor: default sizes,
// counter update ops, saturating arithmetic and PC index/tag extraction.
package bp_pkg;

    localparam int DEF_INDEX_WIDTH = 6;
    localparam int DEF_CTR_WIDTH   = 2;

    typedef enum logic [1:0] {
        CTR_OP_INIT = 2'd0,
        CTR_OP_MAX  = 2'd1,
        CTR_OP_INC  = 2'd2,
        CTR_OP_DEC  = 2'd3
    } ctr_op_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    function automatic logic [31:0] get_index(input logic [31:0] pc, input int iw);
        return (pc >> 2) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] get_tag(input logic [31:0] pc, input int iw);
        return pc >> (iw + 2);
    endfunction

endpackage

// File: rtl/bp_ctr_table.sv
// Direction counter array: one combinational read port, one op-driven
// write port. RD_BYPASS=1 forwards the post-write value to a matching read.
module bp_ctr_table
    import bp_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int CTR_WIDTH   = DEF_CTR_WIDTH,
    parameter int CTR_INIT    = 2 ** (CTR_WIDTH - 1),
    parameter bit RD_BYPASS   = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [INDEX_WIDTH-1:0] rd_idx_i,
    output logic [CTR_WIDTH-1:0]   rd_ctr_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_WIDTH-1:0] wr_idx_i,
    input  logic [1:0]             wr_op_i
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;

    logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
    logic [CTR_WIDTH-1:0] wr_cur;
    logic [CTR_WIDTH-1:0] ctr_d;

    assign wr_cur = ctr_q[wr_idx_i];

    always_comb begin
        ctr_d = wr_cur;
        case (ctr_op_e'(wr_op_i))
            CTR_OP_INIT: ctr_d = CTR_WIDTH'(CTR_INIT);
            CTR_OP_MAX:  ctr_d = '1;
            CTR_OP_INC:  ctr_d = CTR_WIDTH'(sat_inc(32'(wr_cur), CTR_WIDTH));
            CTR_OP_DEC:  ctr_d = CTR_WIDTH'(sat_dec(32'(wr_cur)));
            default:     ctr_d = wr_cur;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WIDTH'(CTR_INIT);
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= ctr_d;
        end
    end

    // Forwarding is suppressed under reset, where the write is discarded.
    always_comb begin
        rd_ctr_o = ctr_q[rd_idx_i];
        if (RD_BYPASS && rst_ni && wr_en_i && (wr_idx_i == rd_idx_i)) begin
            rd_ctr_o = ctr_d;
        end
    end

endmodule

// File: rtl/bimodal_btb_predictor.sv
// Direct-mapped BTB with per-entry bimodal direction counters, trained at commit.
// Optional macro BIMODAL_WR_BYPASS_EN forwards same-cycle updates to the IF lookup.
module bimodal_btb_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int CTR_WIDTH   = DEF_CTR_WIDTH,
    parameter int CTR_INIT    = 2 ** (CTR_WIDTH - 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] IF_pc_i,
    input  logic [31:0] EXMEM_pc_i,
    input  logic [31:0] EXMEM_target_i,
    input  logic        EXMEM_is_br_i,
    input  logic        EXMEM_is_jmp_i,
    input  logic        EXMEM_taken_i,
    output logic        IF_btb_hit_o,
    output logic        IF_pred_taken_o,
    output logic [31:0] IF_pred_target_o
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = 30 - INDEX_WIDTH;
`ifdef BIMODAL_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    logic [INDEX_WIDTH-1:0] if_idx, cm_idx;
    logic [TAG_W-1:0]       if_tag, cm_tag;
    logic                   cm_hit;
    logic                   upd_en;
    logic                   ent_wr;
    ctr_op_e                ctr_op;
    logic [CTR_WIDTH-1:0]   rd_ctr;
    logic                   rd_valid;
    logic [TAG_W-1:0]       rd_tag;
    logic [31:0]            rd_target;

    assign if_idx = INDEX_WIDTH'(get_index(IF_pc_i, INDEX_WIDTH));
    assign if_tag = TAG_W'(get_tag(IF_pc_i, INDEX_WIDTH));
    assign cm_idx = INDEX_WIDTH'(get_index(EXMEM_pc_i, INDEX_WIDTH));
    assign cm_tag = TAG_W'(get_tag(EXMEM_pc_i, INDEX_WIDTH));
    assign cm_hit = valid_q[cm_idx] && (tag_q[cm_idx] == cm_tag);

    // ent_wr rewrites valid/tag/target; upd_en covers any counter change.
    always_comb begin
        upd_en = 1'b0;
        ent_wr = 1'b0;
        ctr_op = CTR_OP_INIT;
        if (EXMEM_is_jmp_i) begin
            upd_en = 1'b1;
            ent_wr = 1'b1;
            ctr_op = CTR_OP_MAX;
        end else if (EXMEM_is_br_i) begin
            if (cm_hit) begin
                upd_en = 1'b1;
                ent_wr = EXMEM_taken_i;
                ctr_op = EXMEM_taken_i ? CTR_OP_INC : CTR_OP_DEC;
            end else if (EXMEM_taken_i) begin
                upd_en = 1'b1;
                ent_wr = 1'b1;
                ctr_op = CTR_OP_INIT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (ent_wr) begin
            valid_q[cm_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && ent_wr) begin
            tag_q[cm_idx]    <= cm_tag;
            target_q[cm_idx] <= EXMEM_target_i;
        end
    end

    bp_ctr_table #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .CTR_WIDTH   (CTR_WIDTH),
        .CTR_INIT    (CTR_INIT),
        .RD_BYPASS   (BYPASS)
    ) u_ctr_table (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rd_idx_i (if_idx),
        .rd_ctr_o (rd_ctr),
        .wr_en_i  (upd_en),
        .wr_idx_i (cm_idx),
        .wr_op_i  (ctr_op)
    );

`ifdef BIMODAL_WR_BYPASS_EN
    always_comb begin
        rd_valid  = valid_q[if_idx];
        rd_tag    = tag_q[if_idx];
        rd_target = target_q[if_idx];
        if (rst_ni && ent_wr && (cm_idx == if_idx)) begin
            rd_valid  = 1'b1;
            rd_tag    = cm_tag;
            rd_target = EXMEM_target_i;
        end
    end
`else
    assign rd_valid  = valid_q[if_idx];
    assign rd_tag    = tag_q[if_idx];
    assign rd_target = target_q[if_idx];
`endif

    assign IF_btb_hit_o     = rd_valid && (rd_tag == if_tag);
    assign IF_pred_taken_o  = IF_btb_hit_o && rd_ctr[CTR_WIDTH-1];
    assign IF_pred_target_o = rd_target;

endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// Bench for bimodal_btb_predictor (INDEX_WIDTH=4, CTR_WIDTH=2): directed
// vector table, a same-cycle forwarding sequence, and a randomized model run.
module tb_bimodal_btb_predictor;

    localparam int IW     = 4;
    localparam int CW     = 2;
    localparam int NENT   = 1 << IW;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int CINIT  = 1 << (CW - 1);
`ifdef BIMODAL_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] IF_pc_i;
    logic [31:0] EXMEM_pc_i;
    logic [31:0] EXMEM_target_i;
    logic        EXMEM_is_br_i;
    logic        EXMEM_is_jmp_i;
    logic        EXMEM_taken_i;
    logic        IF_btb_hit_o;
    logic        IF_pred_taken_o;
    logic [31:0] IF_pred_target_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    bimodal_btb_predictor #(.INDEX_WIDTH(IW), .CTR_WIDTH(CW)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .IF_pc_i          (IF_pc_i),
        .EXMEM_pc_i       (EXMEM_pc_i),
        .EXMEM_target_i   (EXMEM_target_i),
        .EXMEM_is_br_i    (EXMEM_is_br_i),
        .EXMEM_is_jmp_i   (EXMEM_is_jmp_i),
        .EXMEM_taken_i    (EXMEM_taken_i),
        .IF_btb_hit_o     (IF_btb_hit_o),
        .IF_pred_taken_o  (IF_pred_taken_o),
        .IF_pred_target_o (IF_pred_target_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: plain arrays indexed by entry ----
    bit          m_valid [NENT];
    int unsigned m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return pc / (4 * NENT);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = CINIT;
        end
    endtask

    task automatic m_commit(input bit br, input bit jmp, input bit tk,
                            input logic [31:0] pc, input logic [31:0] tgt);
        int  i;
        bit  hit;
        i   = m_idx(pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
        if (jmp) begin
            m_valid[i] = 1'b1; m_tag[i] = m_tagof(pc); m_tgt[i] = tgt; m_ctr[i] = CMAX;
        end else if (br && hit) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (br && tk) begin
            m_valid[i] = 1'b1; m_tag[i] = m_tagof(pc); m_tgt[i] = tgt; m_ctr[i] = CINIT;
        end
    endtask

    task automatic m_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                            output logic [31:0] tgt);
        int i;
        i   = m_idx(pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
        tk  = hit && (m_ctr[i] >= CINIT);
        tgt = m_tgt[i];
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          br;
        bit          jmp;
        bit          tk;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] if_pc;
        bit          e_hit;
        bit          e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit br, input bit jmp, input bit tk,
                                input logic [31:0] pc, input logic [31:0] tgt,
                                input logic [31:0] if_pc, input bit e_hit, input bit e_tk,
                                input logic [31:0] e_tgt);
        vec_t v;
        v.rst = rst; v.br = br; v.jmp = jmp; v.tk = tk; v.pc = pc; v.tgt = tgt;
        v.if_pc = if_pc; v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt;
        return v;
    endfunction

    vec_t vecs [20];

    task automatic apply_vec(input vec_t v, input int n);
        @(negedge clk_i);
        rst_ni = !v.rst;
        EXMEM_is_br_i = v.br; EXMEM_is_jmp_i = v.jmp; EXMEM_taken_i = v.tk;
        EXMEM_pc_i = v.pc; EXMEM_target_i = v.tgt; IF_pc_i = v.if_pc;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        EXMEM_is_br_i = 1'b0; EXMEM_is_jmp_i = 1'b0; EXMEM_taken_i = 1'b0;
        IF_pc_i = v.if_pc;
        #1;
        check($sformatf("vec%0d_hit", n), 32'(IF_btb_hit_o), 32'(v.e_hit));
        check($sformatf("vec%0d_taken", n), 32'(IF_pred_taken_o), 32'(v.e_tk));
        if (v.e_hit) check($sformatf("vec%0d_target", n), IF_pred_target_o, v.e_tgt);
    endtask

    initial begin
        bit          e_hit, e_tk;
        logic [31:0] e_tgt;

        rst_ni = 1'b0; IF_pc_i = '0; EXMEM_pc_i = '0; EXMEM_target_i = '0;
        EXMEM_is_br_i = 1'b0; EXMEM_is_jmp_i = 1'b0; EXMEM_taken_i = 1'b0;

        //                rst br jmp tk  pc      tgt     if_pc   hit tk  tgt
        vecs[0]  = mk(1, 0, 0, 0, 32'h000, 32'h000, 32'h100, 0, 0, 32'h000);
        vecs[1]  = mk(0, 0, 0, 0, 32'h000, 32'h000, 32'h100, 0, 0, 32'h000);
        vecs[2]  = mk(0, 1, 0, 1, 32'h100, 32'h200, 32'h100, 1, 1, 32'h200);
        vecs[3]  = mk(0, 1, 0, 0, 32'h100, 32'h000, 32'h100, 1, 0, 32'h200);
        vecs[4]  = mk(0, 1, 0, 0, 32'h100, 32'h000, 32'h100, 1, 0, 32'h200);
        vecs[5]  = mk(0, 1, 0, 0, 32'h100, 32'h000, 32'h100, 1, 0, 32'h200);
        vecs[6]  = mk(0, 1, 0, 1, 32'h100, 32'h200, 32'h100, 1, 0, 32'h200);
        vecs[7]  = mk(0, 1, 0, 1, 32'h100, 32'h200, 32'h100, 1, 1, 32'h200);
        vecs[8]  = mk(0, 1, 0, 1, 32'h140, 32'h500, 32'h140, 1, 1, 32'h500);
        vecs[9]  = mk(0, 0, 0, 0, 32'h000, 32'h000, 32'h100, 0, 0, 32'h000);
        vecs[10] = mk(0, 1, 0, 0, 32'h180, 32'h777, 32'h140, 1, 1, 32'h500);
        vecs[11] = mk(0, 0, 1, 0, 32'h300, 32'h080, 32'h300, 1, 1, 32'h080);
        vecs[12] = mk(0, 1, 0, 1, 32'h300, 32'h080, 32'h300, 1, 1, 32'h080);
        vecs[13] = mk(0, 1, 0, 0, 32'h300, 32'h000, 32'h300, 1, 1, 32'h080);
        vecs[14] = mk(0, 1, 0, 0, 32'h300, 32'h000, 32'h300, 1, 0, 32'h080);
        vecs[15] = mk(0, 1, 1, 0, 32'h300, 32'h090, 32'h300, 1, 1, 32'h090);
        vecs[16] = mk(0, 1, 0, 0, 32'h300, 32'h000, 32'h300, 1, 1, 32'h090);
        vecs[17] = mk(1, 0, 1, 0, 32'h300, 32'h044, 32'h300, 0, 0, 32'h000);
        vecs[18] = mk(0, 0, 0, 0, 32'h000, 32'h000, 32'h300, 0, 0, 32'h000);
        vecs[19] = mk(0, 0, 0, 0, 32'h000, 32'h000, 32'h140, 0, 0, 32'h000);

        for (int n = 0; n < 20; n++) apply_vec(vecs[n], n);

        // same-cycle allocate and lookup of the same PC on an empty table
        @(negedge clk_i); rst_ni = 1'b0;
        @(posedge clk_i); #1; rst_ni = 1'b1;
        @(negedge clk_i);
        EXMEM_is_br_i = 1'b1; EXMEM_taken_i = 1'b1;
        EXMEM_pc_i = 32'h100; EXMEM_target_i = 32'h200; IF_pc_i = 32'h100;
        #1;
        check("same_cycle_hit", 32'(IF_btb_hit_o), 32'(BYP));
        check("same_cycle_taken", 32'(IF_pred_taken_o), 32'(BYP));
        if (BYP) check("same_cycle_target", IF_pred_target_o, 32'h200);
        @(posedge clk_i); #1;
        EXMEM_is_br_i = 1'b0; EXMEM_taken_i = 1'b0;
        #1;
        check("after_alloc_hit", 32'(IF_btb_hit_o), 32'd1);
        check("after_alloc_target", IF_pred_target_o, 32'h200);

        // randomized run against the model
        @(negedge clk_i); rst_ni = 1'b0;
        @(posedge clk_i); #1; rst_ni = 1'b1;
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            bit          rst, br, jmp, tk;
            logic [31:0] cpc, ipc, ctgt;
            int          r;
            @(negedge clk_i);
            rst  = ($urandom_range(0, 39) == 0);
            r    = int'($urandom_range(0, 9));
            jmp  = (r < 2);
            br   = (r >= 2 && r < 8) || (r == 0);
            tk   = $urandom_range(0, 1) == 1;
            cpc  = (32'($urandom_range(4, 6)) << (IW + 2)) | (32'($urandom_range(0, 3)) << 2);
            ipc  = (32'($urandom_range(4, 6)) << (IW + 2)) | (32'($urandom_range(0, 3)) << 2);
            ctgt = $urandom & 32'hFFFF_FFFC;
            rst_ni = !rst;
            EXMEM_is_br_i = br; EXMEM_is_jmp_i = jmp; EXMEM_taken_i = tk;
            EXMEM_pc_i = cpc; EXMEM_target_i = ctgt; IF_pc_i = ipc;
            #1;
            if (BYP && !rst && (m_idx(cpc) == m_idx(ipc))) begin
                m_commit(br, jmp, tk, cpc, ctgt);
                m_lookup(ipc, e_hit, e_tk, e_tgt);
            end else begin
                m_lookup(ipc, e_hit, e_tk, e_tgt);
                if (rst) m_reset();
                else m_commit(br, jmp, tk, cpc, ctgt);
            end
            check($sformatf("rnd%0d_hit", c), 32'(IF_btb_hit_o), 32'(e_hit));
            check($sformatf("rnd%0d_taken", c), 32'(IF_pred_taken_o), 32'(e_tk));
            if (e_hit) check($sformatf("rnd%0d_target", c), IF_pred_target_o, e_tgt);
        end

        @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
